pll_clk_en_gen: RTL and testbench
=================================

// Module: pll_clk_en_gen
// PURPOSE
//   Post-PLL clock-enable generator and lock qualifier; sits directly behind the PLL wrapper in the PLL output domain.
//   Synchronises and debounces the raw PLL lock and sequences the downstream reset.
//   Produces NUM_CH independent, phase-programmable clock-enable pulse trains, so that slow logic runs on one PLL clock.
// PARAMETERS
//   NUM_CH        4     number of clock-enable channels (1..16)
//   DIV_W         16    width of each divide/phase field
//   SETTLE_CYCLES 1024  cycles the lock must stay high before RUN (>=1)
//   SYNC_STAGES   2     synchroniser depth on pll_locked (>=2)
// PORTS
//   refclk        in   1             sole clock (PLL output clock)
//   rst           in   1             asynchronous, active-high reset
//   pll_locked    in   1             raw PLL lock, asynchronous to refclk
//   div_cfg       in   NUM_CH*DIV_W  per-channel divide ratio D (channel i in bits [i*DIV_W +: DIV_W])
//   phase_cfg     in   NUM_CH*DIV_W  per-channel initial count offset P
//   cfg_load      in   1             one-cycle strobe: latch div_cfg/phase_cfg into shadow regs, realign counters
//   ch_en         in   NUM_CH        per-channel run enable
//   clk_en        out  NUM_CH        one-cycle enable pulses
//   locked        out  1             qualified lock (high only in RUN)
//   rst_out       out  1             downstream synchronous reset, high unless in RUN
//   lock_loss_cnt out  8             lock-loss event count (only with LOCK_LOSS_CNT_EN)
// BEHAVIOUR
//   Reset: state=WAIT_LOCK, synchroniser=0, shadow regs take current div_cfg/phase_cfg.
//   Reset outputs: clk_en=0, locked=0, rst_out=1, lock_loss_cnt=0.
//   lk_s = pll_locked after SYNC_STAGES flops.
//   All outputs are registered.
//   FSM:
//     WAIT_LOCK: lk_s=1 -> SETTLE with settle_cnt=0.
//     SETTLE: settle_cnt increments each cycle. lk_s=0 -> WAIT_LOCK (counter discarded).
//       settle_cnt==SETTLE_CYCLES-1 with lk_s=1 -> RUN.
//     RUN: lk_s=0 -> WAIT_LOCK. Outputs reach locked=0, rst_out=1, clk_en=0 on the next edge; no pulse is emitted in that cycle.
//   On RUN entry: locked=1 and rst_out=0 in the first RUN cycle; every channel counter is loaded with P'.
//   Channel arithmetic: D' = (D==0) ? 1 : D; P' = (P>=D') ? 0 : P.
//   Channel counting (RUN, ch_en[i]=1): cnt==D'-1 -> cnt=0, clk_en[i]=1 next cycle; otherwise cnt+1, clk_en[i]=0.
//   Pulse timing: first pulse D'-P' cycles after RUN entry. D'=1 gives a pulse every cycle.
//   ch_en[i]=0: cnt holds its value, clk_en[i]=0. Re-enabling resumes from the held count.
//   cfg_load in RUN: shadow updated, all counters reloaded with the new P', clk_en=0 that cycle.
//   cfg_load outside RUN: shadow updated only.
//   div_cfg/phase_cfg changes without cfg_load have no effect.
//   Simultaneous lock drop and cfg_load: shadow updates, FSM still goes to WAIT_LOCK.
//   Async rst mid-RUN: immediate return to reset values; no partial pulse.
// CONFIGURATION
//   LOCK_LOSS_CNT_EN defined: port lock_loss_cnt present; 8-bit counter +1 on each RUN->WAIT_LOCK transition.
//     The counter saturates at 255 and is cleared only by rst.
//   LOCK_LOSS_CNT_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//   Package pll_clk_pkg: FSM state enum (WAIT_LOCK, SETTLE, RUN), localparam LOSS_CNT_W=8,
//     function eff_div(D), function eff_phase(P, D').
//   Sub-module pll_clk_en_ch: one channel counter plus registered clk_en; instantiated NUM_CH times via generate.
//   Synchroniser, settle counter and FSM are inline in pll_clk_en_gen.
// TESTING
//   1 Reset: rst=1 with pll_locked=1 -> clk_en=0, locked=0, rst_out=1. Release -> locked=1 exactly SYNC_STAGES+SETTLE_CYCLES+1 cycles later.
//   2 Divide/phase: D={4,1,3,0}, P={0,0,2,0}, all ch_en=1.
//     -> ch0 pulses at RUN+4, +8, ...; ch1 and ch3 pulse every cycle from RUN+1; ch2 pulses at RUN+1, +4, +7.
//   3 Glitch in SETTLE: pll_locked low for 1 cycle at settle_cnt=500 -> state WAIT_LOCK, full SETTLE_CYCLES restart, locked stays 0.
//   4 Lock loss in RUN: drop pll_locked -> locked=0, rst_out=1, clk_en=0 within SYNC_STAGES+1 cycles.
//     With LOCK_LOSS_CNT_EN, lock_loss_cnt 0->1; 300 losses -> 255.
//   5 cfg_load in RUN: D 4->5, P=3 -> clk_en=0 in the load cycle, next pulse 2 cycles later, then every 5 cycles.
//   6 ch_en: drop ch_en[0] at cnt=2 for 10 cycles -> no pulses; re-enable -> pulse 2 cycles later.

Source files
------------

// File: rtl/pll_clk_pkg.sv
// ============================================================================
// Module : pll_clk_pkg
// Brief  : Shared lock-FSM states and channel divide/phase helpers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pll_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int LOSS_CNT_W = 8;
    localparam int FN_W       = 32;

    // A zero divide ratio behaves as divide-by-one.
    function automatic logic [FN_W-1:0] eff_div(input logic [FN_W-1:0] d);
        return (d == '0) ? FN_W'(1) : d;
    endfunction

    // An out-of-range phase offset falls back to zero.
    function automatic logic [FN_W-1:0] eff_phase(input logic [FN_W-1:0] p,
                                                  input logic [FN_W-1:0] dp);
        return (p >= dp) ? '0 : p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_clk_en_ch.sv
// ============================================================================
// Module : pll_clk_en_ch
// Brief  : One clock-enable channel: modulo counter with registered pulse.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pll_clk_en_ch #(
    parameter int DIV_W = 16
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic [DIV_W-1:0] load_phase,
    input  logic [DIV_W-1:0] div_eff,
    input  logic             en,
    output logic             clk_en
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            clk_en <= 1'b0;
        end else if (!run) begin
            clk_en <= 1'b0;
        end else if (load) begin
            cnt    <= load_phase;
            clk_en <= 1'b0;
        end else if (en) begin
            if (cnt == div_eff - DIV_W'(1)) begin
                cnt    <= '0;
                clk_en <= 1'b1;
            end else begin
                cnt    <= cnt + DIV_W'(1);
                clk_en <= 1'b0;
            end
        end else begin
            // Disabled channel freezes its count so it resumes in phase.
            clk_en <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pll_clk_en_gen.sv
// ============================================================================
// Module : pll_clk_en_gen
// Brief  : PLL lock qualifier, downstream reset sequencer and NUM_CH
//          phase-programmable clock-enable generators.
//          Optional: LOCK_LOSS_CNT_EN adds the lock_loss_cnt port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pll_clk_en_gen
    import pll_clk_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int DIV_W         = 16,
    parameter int SETTLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
    input  logic [NUM_CH*DIV_W-1:0] phase_cfg,
    input  logic                    cfg_load,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       clk_en,
    output logic                    locked,
`ifdef LOCK_LOSS_CNT_EN
    output logic [LOSS_CNT_W-1:0]   lock_loss_cnt,
`endif
    output logic                    rst_out
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      lk_s;
    state_t                    state, state_nxt;
    logic [SETTLE_W-1:0]       settle_cnt, settle_nxt;
    logic                      run_nxt;
    logic                      ch_load;
    logic                      shadow_init;
    logic [NUM_CH*DIV_W-1:0]   div_sh, phase_sh;

    assign lk_s    = sync_q[SYNC_STAGES-1];
    assign run_nxt = (state_nxt == RUN);
    // Counters realign on RUN entry and on every in-RUN configuration load.
    assign ch_load = run_nxt && ((state != RUN) || cfg_load);

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        case (state)
            WAIT_LOCK: begin
                if (lk_s) begin
                    state_nxt  = SETTLE;
                    settle_nxt = '0;
                end
            end
            SETTLE: begin
                if (!lk_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    state_nxt = RUN;
                end else begin
                    settle_nxt = settle_cnt + SETTLE_W'(1);
                end
            end
            RUN: begin
                if (!lk_s) state_nxt = WAIT_LOCK;
            end
            default: state_nxt = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            state       <= WAIT_LOCK;
            settle_cnt  <= '0;
            locked      <= 1'b0;
            rst_out     <= 1'b1;
            shadow_init <= 1'b1;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            state       <= state_nxt;
            settle_cnt  <= settle_nxt;
            locked      <= run_nxt;
            rst_out     <= !run_nxt;
            shadow_init <= 1'b0;
        end
    end

    // Shadow copies track the config inputs while in reset and on the
    // first edge after release; after that only cfg_load updates them.
    always_ff @(posedge refclk) begin
        if (shadow_init || cfg_load) begin
            div_sh   <= div_cfg;
            phase_sh <= phase_cfg;
        end
    end

`ifdef LOCK_LOSS_CNT_EN
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_loss_cnt <= '0;
        end else if ((state == RUN) && (state_nxt == WAIT_LOCK) && (lock_loss_cnt != '1)) begin
            lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);
        end
    end
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] src_div, src_ph, ld_div, ld_ph, run_div;

        // A load in the same cycle as cfg_load must use the new values.
        assign src_div = cfg_load ? div_cfg[i*DIV_W +: DIV_W]   : div_sh[i*DIV_W +: DIV_W];
        assign src_ph  = cfg_load ? phase_cfg[i*DIV_W +: DIV_W] : phase_sh[i*DIV_W +: DIV_W];
        assign ld_div  = DIV_W'(eff_div(FN_W'(src_div)));
        assign ld_ph   = DIV_W'(eff_phase(FN_W'(src_ph), FN_W'(ld_div)));
        assign run_div = DIV_W'(eff_div(FN_W'(div_sh[i*DIV_W +: DIV_W])));

        pll_clk_en_ch #(
            .DIV_W (DIV_W)
        ) u_ch (
            .refclk     (refclk),
            .rst        (rst),
            .run        (run_nxt),
            .load       (ch_load),
            .load_phase (ld_ph),
            .div_eff    (run_div),
            .en         (ch_en[i]),
            .clk_en     (clk_en[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_pll_clk_en_gen.sv
// ============================================================================
// Module : tb_pll_clk_en_gen
// Brief  : Scoreboard bench for pll_clk_en_gen against a behavioural model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pll_clk_en_gen;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 8;
    localparam int SC     = 40;
    localparam int SS     = 2;

    logic                    refclk = 1'b0;
    logic                    rst;
    logic                    pll_locked;
    logic [NUM_CH*DIV_W-1:0] div_cfg;
    logic [NUM_CH*DIV_W-1:0] phase_cfg;
    logic                    cfg_load;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       clk_en;
    logic                    locked;
    logic                    rst_out;
    logic [7:0]              llc_dut;

`ifndef LOCK_LOSS_CNT_EN
    assign llc_dut = 8'd0;
`endif

    pll_clk_en_gen #(
        .NUM_CH        (NUM_CH),
        .DIV_W         (DIV_W),
        .SETTLE_CYCLES (SC),
        .SYNC_STAGES   (SS)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .div_cfg       (div_cfg),
        .phase_cfg     (phase_cfg),
        .cfg_load      (cfg_load),
        .ch_en         (ch_en),
        .clk_en        (clk_en),
        .locked        (locked),
`ifdef LOCK_LOSS_CNT_EN
        .lock_loss_cnt (llc_dut),
`endif
        .rst_out       (rst_out)
    );

    always #5 refclk = ~refclk;

    typedef struct packed {
        logic [NUM_CH-1:0] ce;
        logic              lk;
        logic              ro;
        logic [7:0]        llc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    // Monitor: one expected response per clock edge.
    exp_t mon_e;
    initial begin
        forever begin
            @(posedge refclk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("clk_en",  32'(clk_en),  32'(mon_e.ce));
                chk("locked",  32'(locked),  32'(mon_e.lk));
                chk("rst_out", 32'(rst_out), 32'(mon_e.ro));
`ifdef LOCK_LOSS_CNT_EN
                chk("lock_loss_cnt", 32'(llc_dut), 32'(mon_e.llc));
`endif
            end
        end
    end

    // ---------------- reference model ----------------
    bit dly_q[$];
    int streak;
    bit run_m;
    int llc_m;
    int n_m[NUM_CH], dp_m[NUM_CH], pp_m[NUM_CH], sd_m[NUM_CH], sp_m[NUM_CH];

    function automatic int field(logic [NUM_CH*DIV_W-1:0] v, int i);
        logic [DIV_W-1:0] f;
        f = v[i*DIV_W +: DIV_W];
        return int'(f);
    endfunction

    // Lock is qualified once SC+1 consecutive edges have seen the synchronised
    // lock high; channel i pulses on its n-th enabled cycle after a realign
    // whenever (P' + n) is a multiple of D'.
    task automatic cyc();
        exp_t e;
        bit   lk, prev;
        int   d, p;
        e = '0;
        if (rst) begin
            dly_q.delete();
            repeat (SS) dly_q.push_back(1'b0);
            streak = 0;
            run_m  = 1'b0;
            llc_m  = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                sd_m[i] = field(div_cfg, i);
                sp_m[i] = field(phase_cfg, i);
            end
            e.ro = 1'b1;
        end else begin
            lk = dly_q.pop_front();
            dly_q.push_back(pll_locked);
            prev = run_m;
            if (lk) begin
                if (streak <= SC) streak++;
            end else begin
                streak = 0;
            end
            run_m = (streak >= SC + 1);
            if (prev && !run_m && llc_m < 255) llc_m++;
            if (run_m) begin
                if (!prev || cfg_load) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        d = cfg_load ? field(div_cfg, i)   : sd_m[i];
                        p = cfg_load ? field(phase_cfg, i) : sp_m[i];
                        dp_m[i] = (d == 0) ? 1 : d;
                        pp_m[i] = (p >= dp_m[i]) ? 0 : p;
                        n_m[i]  = 0;
                    end
                end else begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_en[i]) begin
                            n_m[i]++;
                            if ((pp_m[i] + n_m[i]) % dp_m[i] == 0) e.ce[i] = 1'b1;
                        end
                    end
                end
            end
            if (cfg_load) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    sd_m[i] = field(div_cfg, i);
                    sp_m[i] = field(phase_cfg, i);
                end
            end
            e.lk  = run_m;
            e.ro  = !run_m;
            e.llc = 8'(llc_m);
        end
        exp_q.push_back(e);
        @(negedge refclk);
    endtask

    task automatic set_cfg(input int i, input int d, input int p);
        div_cfg[i*DIV_W +: DIV_W]   = DIV_W'(d);
        phase_cfg[i*DIV_W +: DIV_W] = DIV_W'(p);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        pll_locked = 1'b1;
        cfg_load   = 1'b0;
        ch_en      = '1;
        div_cfg    = '0;
        phase_cfg  = '0;
        set_cfg(0, 4, 0);
        set_cfg(1, 1, 0);
        set_cfg(2, 3, 2);
        set_cfg(3, 0, 0);
        repeat (3) cyc();
        rst = 1'b0;
        repeat (SS + SC + 20) cyc();

        // Pause channel 0, then resume.
        ch_en[0] = 1'b0;
        repeat (10) cyc();
        ch_en[0] = 1'b1;
        repeat (12) cyc();

        // In-RUN reload, then a config change without load.
        set_cfg(0, 5, 3);
        cfg_load = 1'b1;
        cyc();
        cfg_load = 1'b0;
        set_cfg(0, 9, 9);
        repeat (20) cyc();

        // Lock loss in RUN, then a one-cycle glitch mid-settle.
        pll_locked = 1'b0;
        repeat (6) cyc();
        pll_locked = 1'b1;
        repeat (SS + SC / 2) cyc();
        pll_locked = 1'b0;
        cyc();
        pll_locked = 1'b1;
        repeat (2 * SC) cyc();

        // Lock drop coinciding with cfg_load.
        pll_locked = 1'b0;
        repeat (SS) cyc();
        set_cfg(1, 2, 1);
        cfg_load = 1'b1;
        cyc();
        cfg_load = 1'b0;
        repeat (3) cyc();
        pll_locked = 1'b1;
        repeat (SS + SC + 15) cyc();

        // Random phase.
        repeat (4000) begin
            if (pll_locked) pll_locked = ($urandom_range(0, 149) != 0);
            else            pll_locked = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < NUM_CH; i++) set_cfg(i, $urandom_range(0, 9), $urandom_range(0, 11));
            cfg_load = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) ch_en = NUM_CH'($urandom);
            cyc();
        end

        // Asynchronous reset in the middle of RUN.
        pll_locked = 1'b1;
        cfg_load   = 1'b0;
        ch_en      = '1;
        set_cfg(0, 2, 1);
        set_cfg(1, 1, 0);
        set_cfg(2, 3, 0);
        set_cfg(3, 4, 3);
        cfg_load = 1'b1;
        cyc();
        cfg_load = 1'b0;
        repeat (SS + SC + 10) cyc();
        rst = 1'b1;
        #1;
        chk("async_rst_clk_en",  32'(clk_en),  32'(0));
        chk("async_rst_locked",  32'(locked),  32'(0));
        chk("async_rst_rst_out", 32'(rst_out), 32'(1));
        repeat (2) cyc();
        rst = 1'b0;
        repeat (SS + SC + 12) cyc();

`ifdef LOCK_LOSS_CNT_EN
        repeat (300) begin
            pll_locked = 1'b1;
            repeat (SS + SC + 2) cyc();
            pll_locked = 1'b0;
            repeat (SS + 1) cyc();
        end
        cyc();
`endif

        @(posedge refclk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
